div_issue_ctrl: RTL and testbench

//  EXE-stage requester for the iterative divider. Issues DIV/DIVU operands, holds the pipeline while the divide runs,

---
 rtl/div_issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// EXE-stage requester for the iterative divider. Sends DIV/DIVU operands to the
// divider and holds the pipeline while the divide runs. It captures the
// one-cycle result pulse and writes HI (remainder) and LO (quotient) when the
// instruction leaves EXE. A flush cancels the divider. A watchdog aborts a
// divide that never completes.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   ex_*               EXE-stage instruction: valid, is_div, signed, operands,
//                      and advance-to-MEM
//   flush_i            kills the EXE instruction (exception / ERET)
//   stall_o            holds EXE while the divide is unfinished
//   div_*_o            request, cancel, signed flag and operands to the divider
//   div_*_i            operand accept, result pulse, quotient, remainder
//   hilo_we_o, hi_o,   one-cycle HI/LO write strobe with the registered result
//   lo_o
//   busy_o             controller is not idle
//   timeout_o          sticky watchdog flag; only reset clears it
//   dbg_state          current FSM state (0 idle, 1 wait, 2 done)
//
// Handshake: the divider takes the operands in a cycle where div_req_o and
// div_oprand_ok_i are both high. div_data_ok_i is a single-cycle pulse, and
// quotient/remainder are valid only in that cycle. A pulse is ignored unless
// the controller is waiting for it.
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   input  logic        ex_is_div_i,
   input  logic        ex_signed_i,
   input  logic [31:0] ex_src_a_i,
   input  logic [31:0] ex_src_b_i,
   input  logic        ex_adv_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        div_req_o,
   output logic        div_cancel_o,
   output logic        div_signed_o,
   output logic [31:0] div_dividend_o,
   output logic [31:0] div_divisor_o,
   input  logic        div_oprand_ok_i,
   input  logic        div_data_ok_i,
   input  logic [31:0] div_quotient_i,
   input  logic [31:0] div_remainder_i,
   output logic        hilo_we_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        busy_o,
   output logic        timeout_o,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pend;
   logic             wd_last;

   assign pend    = ex_valid_i & ex_is_div_i & ~flush_i;
   // Last WAIT cycle the watchdog allows before it aborts the divide.
   assign wd_last = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         hi_o      <= '0;
         lo_o      <= '0;
         timeout_o <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pend && div_oprand_ok_i) begin
                  state <= S_WAIT;
                  cnt   <= '0;
               end
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               // A flush wins over a result arriving in the same cycle.
               if (flush_i) begin
                  state <= S_IDLE;
               end else if (div_data_ok_i) begin
                  lo_o  <= div_quotient_i;
                  hi_o  <= div_remainder_i;
                  state <= S_DONE;
               end else if (wd_last) begin
                  timeout_o <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               // The instruction stays in DONE until it leaves EXE. This
               // prevents a second request for the same instruction.
               if (flush_i || ex_adv_i) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes and pass-through operands are combinational. Reset also gates
   // them, so every output is 0 for as long as rst is low.
   always_comb begin
      div_req_o    = 1'b0;
      stall_o      = 1'b0;
      div_cancel_o = 1'b0;
      hilo_we_o    = 1'b0;
      if (rst) begin
         unique case (state)
            S_IDLE: begin
               div_req_o = pend;
               stall_o   = pend;
            end
            S_WAIT: begin
               stall_o      = 1'b1;
               div_cancel_o = flush_i | (~div_data_ok_i & wd_last);
            end
            S_DONE: begin
               hilo_we_o = ex_adv_i & ~flush_i;
            end
            default: ;
         endcase
      end
   end

   assign div_signed_o   = rst & ex_signed_i;
   assign div_dividend_o = rst ? ex_src_a_i : 32'd0;
   assign div_divisor_o  = rst ? ex_src_b_i : 32'd0;
   assign busy_o         = rst & (state != S_IDLE);
   assign dbg_state      = state;

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
   localparam int TIMEOUT = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid_i, ex_is_div_i, ex_signed_i, ex_adv_i, flush_i;
   logic [31:0] ex_src_a_i, ex_src_b_i;
   logic        stall_o, div_req_o, div_cancel_o, div_signed_o;
   logic [31:0] div_dividend_o, div_divisor_o;
   logic        div_oprand_ok_i, div_data_ok_i;
   logic [31:0] div_quotient_i, div_remainder_i;
   logic        hilo_we_o, busy_o, timeout_o;
   logic [31:0] hi_o, lo_o;
   logic [1:0]  dbg_state;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   logic [31:0] last_hi = 32'd0;
   logic [31:0] last_lo = 32'd0;

   div_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .ex_valid_i(ex_valid_i), .ex_is_div_i(ex_is_div_i), .ex_signed_i(ex_signed_i),
      .ex_src_a_i(ex_src_a_i), .ex_src_b_i(ex_src_b_i), .ex_adv_i(ex_adv_i),
      .flush_i(flush_i), .stall_o(stall_o), .div_req_o(div_req_o),
      .div_cancel_o(div_cancel_o), .div_signed_o(div_signed_o),
      .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
      .div_oprand_ok_i(div_oprand_ok_i), .div_data_ok_i(div_data_ok_i),
      .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
      .hilo_we_o(hilo_we_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o),
      .timeout_o(timeout_o), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge; checks happen on the falling edge
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // divider stub result
   task automatic stub_calc(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r);
      if (sgn) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   // One divide: operand acceptance is held off for `hold` cycles, and data_ok
   // arrives `lat` cycles after acceptance. The instruction then waits one cycle
   // in DONE and advances.
   task automatic do_div(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input int lat,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int          stalls;
      logic [31:0] q, r;
      logic [63:0] e;
      stalls = 0;
      exp_q.push_back({exp_hi, exp_lo});
      ex_valid_i = 1'b1; ex_is_div_i = 1'b1; ex_signed_i = sgn;
      ex_src_a_i = a; ex_src_b_i = b; ex_adv_i = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         div_oprand_ok_i = (i == hold);
         @(negedge clk);
         chk({nm, "_req_idle"}, div_req_o, 1'b1);
         chk({nm, "_busy_idle"}, busy_o, 1'b0);
         if (i == 0) begin
            chk({nm, "_dividend"}, div_dividend_o, a);
            chk({nm, "_divisor"}, div_divisor_o, b);
            chk({nm, "_signed"}, div_signed_o, sgn);
         end
         if (stall_o) stalls++;
         next_cycle();
      end
      div_oprand_ok_i = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         if (k == lat) begin
            stub_calc(sgn, a, b, q, r);
            div_data_ok_i = 1'b1; div_quotient_i = q; div_remainder_i = r;
         end
         @(negedge clk);
         chk({nm, "_req_wait"}, div_req_o, 1'b0);
         chk({nm, "_cancel_wait"}, div_cancel_o, 1'b0);
         if (stall_o) stalls++;
         next_cycle();
         div_data_ok_i = 1'b0;
         div_quotient_i = $urandom; div_remainder_i = $urandom;
      end
      @(negedge clk);
      chk({nm, "_stall_cycles"}, stalls, hold + 1 + lat);
      chk({nm, "_stall_done"}, stall_o, 1'b0);
      chk({nm, "_no_reissue"}, div_req_o, 1'b0);
      chk({nm, "_we_hold"}, hilo_we_o, 1'b0);
      next_cycle();
      ex_adv_i = 1'b1;
      @(negedge clk);
      chk({nm, "_we"}, hilo_we_o, 1'b1);
      if (exp_q.size() == 0) begin
         chk({nm, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({nm, "_hi"}, hi_o, e[63:32]);
         chk({nm, "_lo"}, lo_o, e[31:0]);
         last_hi = e[63:32]; last_lo = e[31:0];
      end
      next_cycle();
      ex_adv_i = 1'b0; ex_valid_i = 1'b0;
   endtask

   initial begin : main
      logic [31:0] ra, rb;
      // reset, with a divide presented at the inputs to exercise output gating
      rst = 1'b0; ex_valid_i = 1'b1; ex_is_div_i = 1'b1; ex_signed_i = 1'b1;
      ex_src_a_i = 32'h1234; ex_src_b_i = 32'h5; ex_adv_i = 1'b0; flush_i = 1'b0;
      div_oprand_ok_i = 1'b0; div_data_ok_i = 1'b0;
      div_quotient_i = 32'd0; div_remainder_i = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", div_req_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_cancel", div_cancel_o, 1'b0);
      chk("rst_we", hilo_we_o, 1'b0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_timeout", timeout_o, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      next_cycle();
      ex_valid_i = 1'b0; rst = 1'b1;
      next_cycle();

      // a valid non-divide does not request
      ex_valid_i = 1'b1; ex_is_div_i = 1'b0;
      @(negedge clk);
      chk("nondiv_req", div_req_o, 1'b0);
      chk("nondiv_stall", stall_o, 1'b0);
      next_cycle();
      ex_valid_i = 1'b0;

      // back-to-back divides; each one starts in the cycle after the previous write
      do_div("div7_2", 1'b1, 32'd7, 32'd2, 0, 32, 32'h00000003, 32'h00000001);
      do_div("divneg", 1'b1, 32'hFFFFFFF9, 32'h2, 0, 32, 32'hFFFFFFFD, 32'hFFFFFFFF);
      do_div("divu_hold", 1'b0, 32'hFFFFFFFF, 32'h10, 3, 32, 32'h0FFFFFFF, 32'h0000000F);
      do_div("lat1", 1'b1, 32'hFFFFFF9C, 32'd7, 0, 1, 32'hFFFFFFF2, 32'hFFFFFFFE);
      ra = $urandom; rb = $urandom_range(1, 1000);
      do_div("lat_max", 1'b0, ra, rb, 1, TIMEOUT - 1, ra / rb, ra % rb);

      // flush 10 cycles after acceptance, with a coincident result pulse
      ex_valid_i = 1'b1; ex_is_div_i = 1'b1; ex_signed_i = 1'b0;
      ex_src_a_i = 32'd100; ex_src_b_i = 32'd3; div_oprand_ok_i = 1'b1;
      @(negedge clk);
      chk("fl_req", div_req_o, 1'b1);
      next_cycle();
      div_oprand_ok_i = 1'b0;
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         chk("fl_cancel_pre", div_cancel_o, 1'b0);
         next_cycle();
      end
      flush_i = 1'b1; div_data_ok_i = 1'b1;
      div_quotient_i = 32'hDEADBEEF; div_remainder_i = 32'hCAFEF00D;
      @(negedge clk);
      chk("fl_cancel", div_cancel_o, 1'b1);
      chk("fl_we", hilo_we_o, 1'b0);
      next_cycle();
      flush_i = 1'b0; div_data_ok_i = 1'b0; ex_valid_i = 1'b0;
      @(negedge clk);
      chk("fl_idle", busy_o, 1'b0);
      chk("fl_cancel_post", div_cancel_o, 1'b0);
      chk("fl_hi_keep", hi_o, last_hi);
      chk("fl_lo_keep", lo_o, last_lo);
      next_cycle();
      div_data_ok_i = 1'b1;   // late stale pulse
      @(negedge clk);
      chk("stale_we", hilo_we_o, 1'b0);
      next_cycle();
      div_data_ok_i = 1'b0;
      @(negedge clk);
      chk("stale_idle", busy_o, 1'b0);
      chk("stale_hi", hi_o, last_hi);
      chk("stale_lo", lo_o, last_lo);
      next_cycle();

      // watchdog: the divider never answers
      ex_valid_i = 1'b1; ex_is_div_i = 1'b1; ex_signed_i = 1'b1;
      ex_src_a_i = 32'd50; ex_src_b_i = 32'd5; div_oprand_ok_i = 1'b1;
      next_cycle();
      div_oprand_ok_i = 1'b0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk);
         chk("wd_cancel", div_cancel_o, (k == TIMEOUT));
         chk("wd_stall", stall_o, 1'b1);
         if (k == TIMEOUT) chk("wd_flag_pre", timeout_o, 1'b0);
         next_cycle();
      end
      @(negedge clk);
      chk("wd_flag", timeout_o, 1'b1);
      chk("wd_done_stall", stall_o, 1'b0);
      chk("wd_hi_keep", hi_o, last_hi);
      chk("wd_lo_keep", lo_o, last_lo);
      next_cycle();
      ex_adv_i = 1'b1;
      @(negedge clk);
      chk("wd_we", hilo_we_o, 1'b1);
      next_cycle();
      ex_adv_i = 1'b0; ex_valid_i = 1'b0;
      @(negedge clk);
      chk("wd_idle", busy_o, 1'b0);
      chk("wd_sticky", timeout_o, 1'b1);
      next_cycle();

      // reset in the middle of WAIT
      ex_valid_i = 1'b1; ex_is_div_i = 1'b1; div_oprand_ok_i = 1'b1;
      next_cycle();
      div_oprand_ok_i = 1'b0;
      repeat (5) next_cycle();
      rst = 1'b0;
      #1;
      chk("mr_stall", stall_o, 1'b0);
      chk("mr_busy", busy_o, 1'b0);
      chk("mr_req", div_req_o, 1'b0);
      chk("mr_cancel", div_cancel_o, 1'b0);
      chk("mr_timeout", timeout_o, 1'b0);
      chk("mr_hi", hi_o, 32'd0);
      chk("mr_lo", lo_o, 32'd0);
      chk("mr_dividend", div_dividend_o, 32'd0);
      ex_valid_i = 1'b0;
      next_cycle();
      rst = 1'b1;
      next_cycle();

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
